cla_nibble_sequencer: RTL and testbench

//  Multi-cycle adder controller. Performs a WIDTH-bit add using one shared
//  4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
//  A registered carry chains between nibbles.

---
 rtl/cla_nibble_sequencer.sv | 141 ++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: WIDTH-bit adder built from one shared 4-bit
// carry-lookahead slice, processing one nibble per cycle, LSB nibble first.
// A registered carry links consecutive nibbles.
// Optional feature macro: CLA_SEQ_SUB_EN (enables subtraction through the sub port).
// WIDTH must be a multiple of 4 and at least 8.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bop;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_bop_in;
  logic             w_cin_in;
  logic             w_unused;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:0]       w_c;
  logic [3:0]       w_sum;

  // Operand selection at accept time: invert B and force carry-in for subtract.
`ifdef CLA_SEQ_SUB_EN
  assign w_bop_in = sub ? ~B : B;
  assign w_cin_in = sub ? 1'b1 : Cin;
  assign w_unused = 1'b0;
`else
  assign w_bop_in = B;
  assign w_cin_in = Cin;
  assign w_unused = sub;
`endif

  // A new op is taken only when the controller is not mid-run.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_idx == IW'(NIB - 1));

  // Shared 4-bit carry-lookahead slice fed from the current nibble of the op regs.
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_bop[{r_idx, 2'b00} +: 4];
  assign w_p     = w_a_nib ^ w_b_nib;
  assign w_g     = w_a_nib & w_b_nib;
  assign w_c[0]  = r_carry;
  assign w_c[1]  = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4]  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_sum   = w_p ^ w_c[3:0];

  // State register; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NIB cycles, DONE for one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one sum nibble per RUN cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_a     <= '0;
      r_bop   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_bop   <= w_bop_in;
      r_carry <= w_cin_in;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s[{r_idx, 2'b00} +: 4] <= w_sum;
      r_carry                  <= w_c[4];
      if (w_last) begin
        // Flags land on the same edge that enters DONE; the MSB of S is the
        // top bit of the nibble being written right now.
        r_cout <= w_c[4];
        r_ovf  <= (r_a[WIDTH-1] == r_bop[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign S    = r_s;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Testbench for cla_nibble_sequencer (WIDTH=16). Expected results are pushed
// to a scoreboard queue when an op is started and popped when done pulses.
module tb_cla_nibble_sequencer;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  // Reference: plain full-width addition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sb_sub);
    exp_t       e;
    logic [W-1:0] bop;
    logic       c;
    logic [W:0] t;
    bop = b;
    c   = cin;
`ifdef CLA_SEQ_SUB_EN
    if (sb_sub) begin
      bop = ~b;
      c   = 1'b1;
    end
`else
    if (sb_sub) c = cin;
`endif
    t      = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, c};
    e.s    = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == bop[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive a one-cycle start and record the expected result; returns #1 after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic s_sub);
    @(posedge CLK); #1;
    A = a; B = b; Cin = cin; sub = s_sub; start = 1'b1;
    sb.push_back(model(a, b, cin, s_sub));
    @(posedge CLK); #1;
    start = 1'b0;
    $display("start A=%h B=%h Cin=%0b sub=%0b", a, b, cin, s_sub);
  endtask

  // Bounded wait for done, sampled on falling edges.
  task automatic wait_done(output bit found, output int cyc, output int busy_cyc);
    found = 1'b0; cyc = 0; busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy, done, S, Cout, Ovf} !== {2'b00, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got busy=%0b done=%0b S=%h Cout=%0b Ovf=%0b required all 0",
               busy, done, S, Cout, Ovf);
    end
    $display("reset busy=%0b done=%0b S=%h", busy, done, S);
  endtask

  task automatic test_basic_add;
    bit found; int cyc; int bc; exp_t e;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(found, cyc, bc);
    checks++;
    if (!found) begin errors++; $display("FAIL t1_timeout no done within bound"); end
    e = sb.pop_front();
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL t1_latency got=%0d required=5", cyc); end
    checks++;
    if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf} || e.s !== 16'h5555) begin
      errors++;
      $display("FAIL t1_result got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
               S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    $display("t1 S=%h Cout=%0b Ovf=%0b latency=%0d", S, Cout, Ovf, cyc);
    @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got done=%0b required 0", done); end
  endtask

  task automatic test_carry_ripple;
    bit found; int cyc; int bc; exp_t e;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(found, cyc, bc);
    checks++;
    if (!found) begin errors++; $display("FAIL t2_timeout no done within bound"); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf} || {S, Cout, Ovf} !== {16'h0000, 2'b10}) begin
      errors++;
      $display("FAIL t2_result got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
               S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    $display("t2 S=%h Cout=%0b Ovf=%0b", S, Cout, Ovf);
  endtask

  // Overflow case; also scrambles inputs during the run to show they are ignored.
  task automatic test_overflow_busy;
    bit found; int cyc; int bc; exp_t e;
    start_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    bc = 1;  // the RUN cycle already under way when start_op returns
    cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      @(negedge CLK);
      if (i == 0) bc = 0;
      if (busy) bc++;
      if (done) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL t3_timeout no done within bound"); end
    e = sb.pop_front();
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL t3_busy_cycles got=%0d required=4", bc); end
    checks++;
    if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf} || {S, Cout, Ovf} !== {16'h8000, 2'b01}) begin
      errors++;
      $display("FAIL t3_result got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
               S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    $display("t3 S=%h Cout=%0b Ovf=%0b busy_cycles=%0d", S, Cout, Ovf, bc);
  endtask

  task automatic test_back_to_back;
    bit found; int cyc; int bc; exp_t e;
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    // Second start two cycles into the run must be ignored.
    @(posedge CLK); @(posedge CLK); #1;
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(found, cyc, bc);
    checks++;
    if (!found) begin errors++; $display("FAIL t4a_timeout no done within bound"); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf} || S !== 16'h1010) begin
      errors++;
      $display("FAIL t4a_result got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
               S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    $display("t4a S=%h Cout=%0b Ovf=%0b", S, Cout, Ovf);
    // Start during the DONE cycle: accepted with no IDLE gap.
    A = 16'h0001; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0));
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy, done, S} !== {2'b10, 16'h0000}) begin
      errors++;
      $display("FAIL t4b_no_gap got busy=%0b done=%0b S=%h required busy=1 done=0 S=0000",
               busy, done, S);
    end
    wait_done(found, cyc, bc);
    checks++;
    if (!found) begin errors++; $display("FAIL t4b_timeout no done within bound"); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf} || S !== 16'h0002) begin
      errors++;
      $display("FAIL t4b_result got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
               S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    $display("t4b S=%h Cout=%0b Ovf=%0b", S, Cout, Ovf);
  endtask

  task automatic test_reset_mid_op;
    int pulses; exp_t e;
    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    e = sb.pop_front();  // this op is aborted and never completes
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy, done, S, Cout, Ovf} !== {2'b00, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL t5_after_reset got busy=%0b done=%0b S=%h Cout=%0b Ovf=%0b required all 0",
               busy, done, S, Cout, Ovf);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL t5_no_done got active_cycles=%0d required=0", pulses); end
    $display("t5 reset mid-op busy=%0b S=%h active_cycles=%0d", busy, S, pulses);
  endtask

  task automatic test_subtract;
    bit found; int cyc; int bc; exp_t e;
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    ta[0] = 16'h0005; tb[0] = 16'h0007;
    ta[1] = 16'h8000; tb[1] = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      start_op(ta[k], tb[k], 1'b0, 1'b1);
      wait_done(found, cyc, bc);
      checks++;
      if (!found) begin errors++; $display("FAIL t6_timeout op=%0d no done within bound", k); end
      e = sb.pop_front();
      checks++;
      if ({S, Cout, Ovf} !== {e.s, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL t6_result op=%0d got S=%h C=%0b V=%0b required S=%h C=%0b V=%0b",
                 k, S, Cout, Ovf, e.s, e.cout, e.ovf);
      end
      $display("t6 op=%0d S=%h Cout=%0b Ovf=%0b", k, S, Cout, Ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_overflow_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_subtract();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
